// File: rtl/lock_input_conditioner.sv
// Front end for the digital lock: synchronizes and debounces the three command
// buttons and the digit switches, then emits one command pulse per physical press.
module lock_input_conditioner #(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ent,
  input  logic       btn_clr,
  input  logic       btn_change,
  input  logic [3:0] sw_raw,
  output logic       ent,
  output logic       clr,
  output logic       change,
  output logic [3:0] sw,
  output logic [2:0] btn_level
);

  typedef enum logic [0:0] {
    ARMED = 1'b0,
    HELD  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       btn_raw_s;
  logic [2:0]       btn_meta_r;
  logic [2:0]       btn_sync_r;
  logic [3:0]       sw_meta_r;
  logic [3:0]       sw_sync_r;
  logic [CNT_W-1:0] cnt_r [3];
  logic [2:0]       lvl_r;
  logic [2:0]       lvl_prev_r;
  logic [2:0]       rise_s;
  state_t           state_r;
  logic             ent_r;
  logic             clr_r;
  logic             change_r;
  logic [3:0]       sw_r;

  // Bit order {change, clr, ent} is shared by every per-button vector.
  assign btn_raw_s = {btn_change, btn_clr, btn_ent};
  assign rise_s    = lvl_r & ~lvl_prev_r;

  // Two-flop synchronizers for buttons and digit switches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_meta_r <= 3'b000;
      btn_sync_r <= 3'b000;
      sw_meta_r  <= 4'h0;
      sw_sync_r  <= 4'h0;
    end else begin
      btn_meta_r <= btn_raw_s;
      btn_sync_r <= btn_meta_r;
      sw_meta_r  <= sw_raw;
      sw_sync_r  <= sw_meta_r;
    end
  end

  // Per-button debounce: any disagreement run shorter than DB_CYCLES is forgotten
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        cnt_r[i] <= '0;
      end
      lvl_r      <= 3'b000;
      lvl_prev_r <= 3'b000;
    end else begin
      lvl_prev_r <= lvl_r;
      for (int i = 0; i < 3; i++) begin
        if (btn_sync_r[i] == lvl_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_LAST) begin
          cnt_r[i] <= '0;
          lvl_r[i] <= ~lvl_r[i];
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  // Command FSM: one pulse per press, clr > change > ent, then lock out until all released
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ARMED;
      ent_r    <= 1'b0;
      clr_r    <= 1'b0;
      change_r <= 1'b0;
      sw_r     <= 4'h0;
    end else begin
      ent_r    <= 1'b0;
      clr_r    <= 1'b0;
      change_r <= 1'b0;
      case (state_r)
        ARMED: begin
          if (rise_s[1]) begin
            clr_r   <= 1'b1;
            state_r <= HELD;
          end else if (rise_s[2]) begin
            change_r <= 1'b1;
            state_r  <= HELD;
          end else if (rise_s[0]) begin
            ent_r   <= 1'b1;
            sw_r    <= sw_sync_r;
            state_r <= HELD;
          end else begin
            state_r <= ARMED;
          end
        end
        HELD: begin
          if (lvl_r == 3'b000) begin
            state_r <= ARMED;
          end else begin
            state_r <= HELD;
          end
        end
        default: begin
          state_r <= ARMED;
        end
      endcase
    end
  end

  assign ent       = ent_r;
  assign clr       = clr_r;
  assign change    = change_r;
  assign sw        = sw_r;
  assign btn_level = lvl_r;

endmodule
